// File: rtl/imt_mem_arbiter.sv
// -----------------------------------------------------------------------------
// imt_mem_arbiter
//
// Merges a core's instruction-fetch port and data port onto a single
// downstream memory bus. Only one transaction is in flight at a time. When
// both ports ask in the same cycle, the port that was not granted last time
// wins.
//
// Parameters
//   ADDR_RESET_PRIO : port favoured by the first simultaneous conflict after
//                     reset (0 = instruction, 1 = data)
//
// Ports
//   clk, resetn                 : clock, asynchronous active-low reset
//   instr_valid / instr_addr    : instruction-fetch request (read-only)
//   instr_ready / instr_rdata   : fetch completion pulse and fetched word
//   mem_valid / mem_instr /
//   mem_addr / mem_wdata /
//   mem_wstrb                   : data-port request
//   mem_ready / mem_rdata       : data-port completion pulse and read word
//   bus_valid / bus_instr /
//   bus_addr / bus_wdata /
//   bus_wstrb                   : merged downstream request (held until ready)
//   bus_ready / bus_rdata       : downstream completion and read data
//
// State table
//   IDLE  | no transaction; arbitrate on any valid request
//   BUS_I | instruction request on the bus, waiting for bus_ready
//   BUS_D | data request on the bus, waiting for bus_ready
//   RESP  | one-cycle ready pulse to the granted port
// -----------------------------------------------------------------------------
module imt_mem_arbiter #(
  parameter bit ADDR_RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        instr_valid,
  input  logic [31:0] instr_addr,
  output logic        instr_ready,
  output logic [31:0] instr_rdata,

  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,

  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;

  // Port granted most recently: 0 = instruction, 1 = data.
  logic   last_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      // Starting from the complement makes the first conflict go to
      // ADDR_RESET_PRIO.
      last_grant  <= ~ADDR_RESET_PRIO;
      bus_valid   <= 1'b0;
      bus_instr   <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;
      instr_rdata <= '0;
      mem_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready <= 1'b0;
          mem_ready   <= 1'b0;
          // Instruction wins when it is alone, or when both ask and data
          // had the previous grant.
          if (instr_valid && (!mem_valid || last_grant)) begin
            state      <= BUS_I;
            last_grant <= 1'b0;
            bus_valid  <= 1'b1;
            bus_instr  <= 1'b1;
            bus_addr   <= instr_addr;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
          end else if (mem_valid) begin
            state      <= BUS_D;
            last_grant <= 1'b1;
            bus_valid  <= 1'b1;
            bus_instr  <= mem_instr;
            bus_addr   <= mem_addr;
            bus_wdata  <= mem_wdata;
            bus_wstrb  <= mem_wstrb;
          end
        end

        // The bus fields are not touched here, so they hold whatever was
        // latched at grant regardless of later core-side changes.
        BUS_I: begin
          if (bus_ready) begin
            state       <= RESP;
            bus_valid   <= 1'b0;
            instr_ready <= 1'b1;
            instr_rdata <= bus_rdata;
          end
        end

        BUS_D: begin
          if (bus_ready) begin
            state     <= RESP;
            bus_valid <= 1'b0;
            mem_ready <= 1'b1;
            mem_rdata <= bus_rdata;
          end
        end

        RESP: begin
          state       <= IDLE;
          instr_ready <= 1'b0;
          mem_ready   <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          bus_valid   <= 1'b0;
          instr_ready <= 1'b0;
          mem_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imt_mem_arbiter.sv
module tb_imt_mem_arbiter;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_valid;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_valid;
  logic        bus_instr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  imt_mem_arbiter #(.ADDR_RESET_PRIO(1'b0)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr_valid (instr_valid),
    .instr_addr  (instr_addr),
    .instr_ready (instr_ready),
    .instr_rdata (instr_rdata),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .bus_valid   (bus_valid),
    .bus_instr   (bus_instr),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus queues (requests the core drivers will issue)
  bus_req_t    i_req_q[$];
  bus_req_t    d_req_q[$];
  // scoreboard: expected bus request per port, expected rdata per completion
  bus_req_t    i_exp_q[$];
  bus_req_t    d_exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rd_fix_q[$];
  // ready pulses observed on the DUT outputs: 0 = instr, 1 = data
  int          grant_log[$];

  int fix_wait   = 0;   // <0: random slave wait states
  int stray_mode = 0;   // 0: none, 1: random, 2: bus_ready held high while idle
  bit i_busy = 0, d_busy = 0;
  bit i_granted = 0, d_granted = 0;
  int n_ipulse = 0, n_mpulse = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    n_chk++;
    n_err++;
    $display("FAIL %s: actual=%s", name, what);
  endtask

  function automatic bus_req_t mk_i(input logic [31:0] a);
    return {1'b1, a, 32'h0, 4'h0};
  endfunction

  function automatic bus_req_t mk_d(input logic ins, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] ws);
    return {ins, a, wd, ws};
  endfunction

  // instruction-port core driver
  initial begin
    int age;
    bus_req_t r;
    instr_valid = 1'b0;
    instr_addr  = '0;
    age = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        instr_valid = 1'b0;
        i_busy = 0;
        continue;
      end
      if (i_busy) begin
        age++;
        if (instr_ready) begin
          instr_valid = 1'b0;
          i_busy = 0;
        end else if (age > 400) begin
          report_fail("instr_timeout", "no instr_ready");
          instr_valid = 1'b0;
          i_busy = 0;
        end else if (i_granted) begin
          instr_addr = instr_addr + 32'h1000;
        end
      end
      if (!i_busy && i_req_q.size() > 0) begin
        r = i_req_q.pop_front();
        instr_addr  = r.addr;
        instr_valid = 1'b1;
        i_exp_q.push_back(r);
        i_busy = 1;
        i_granted = 0;
        age = 0;
      end
    end
  end

  // data-port core driver; scrambles its fields once after being granted
  initial begin
    int age;
    bit scr;
    bus_req_t r;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    age = 0;
    scr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mem_valid = 1'b0;
        d_busy = 0;
        continue;
      end
      if (d_busy) begin
        age++;
        if (mem_ready) begin
          mem_valid = 1'b0;
          d_busy = 0;
        end else if (age > 400) begin
          report_fail("mem_timeout", "no mem_ready");
          mem_valid = 1'b0;
          d_busy = 0;
        end else if (d_granted && !scr) begin
          mem_addr  = mem_addr + 32'h1000;
          mem_wdata = ~mem_wdata;
          mem_wstrb = ~mem_wstrb;
          mem_instr = ~mem_instr;
          scr = 1;
        end
      end
      if (!d_busy && d_req_q.size() > 0) begin
        r = d_req_q.pop_front();
        mem_instr = r.instr;
        mem_addr  = r.addr;
        mem_wdata = r.wdata;
        mem_wstrb = r.wstrb;
        mem_valid = 1'b1;
        d_exp_q.push_back(r);
        d_busy = 1;
        d_granted = 0;
        scr = 0;
        age = 0;
      end
    end
  end

  // downstream memory model
  initial begin
    int wcnt;
    bus_ready = 1'b0;
    bus_rdata = '0;
    wcnt = -1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus_ready = 1'b0;
        wcnt = -1;
      end else if (bus_valid) begin
        if (wcnt < 0) wcnt = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
        if (wcnt == 0) begin
          bus_ready = 1'b1;
          bus_rdata = (rd_fix_q.size() > 0) ? rd_fix_q.pop_front() : $urandom;
          rd_q.push_back(bus_rdata);
          wcnt = -1;
        end else begin
          bus_ready = 1'b0;
          wcnt--;
        end
      end else begin
        wcnt = -1;
        bus_rdata = $urandom;
        case (stray_mode)
          1:       bus_ready = ($urandom_range(0, 3) == 0);
          2:       bus_ready = 1'b1;
          default: bus_ready = 1'b0;
        endcase
      end
    end
  end

  // monitor + reference model: one request in flight, alternate on conflict,
  // ready exactly one edge after bus_ready is seen with a live request,
  // one dead cycle after each completion.
  initial begin
    bit p_bv, p_rsp, cur_d, last_d, comp, gd;
    bit e_bv, e_ir, e_mr;
    bus_req_t cur;
    logic [31:0] m_ir, m_mr;
    p_bv = 0; p_rsp = 0; cur_d = 0; last_d = 1;
    m_ir = '0; m_mr = '0; cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        check("reset_bus", {bus_valid, bus_instr, bus_addr, bus_wdata, bus_wstrb,
                            instr_ready, mem_ready}, '0);
        check("reset_rdata", {instr_rdata, mem_rdata}, '0);
        p_bv = 0; p_rsp = 0; last_d = 1;
        m_ir = '0; m_mr = '0;
        i_exp_q.delete(); d_exp_q.delete(); rd_q.delete();
        i_granted = 0; d_granted = 0;
        continue;
      end
      comp = p_bv && bus_ready;
      e_ir = comp && !cur_d;
      e_mr = comp && cur_d;
      if (p_bv) begin
        e_bv = !bus_ready;
      end else if (p_rsp) begin
        e_bv = 0;
      end else if (instr_valid || mem_valid) begin
        gd = (instr_valid && mem_valid) ? !last_d : mem_valid;
        last_d = gd;
        cur_d  = gd;
        e_bv   = 1;
        if (gd) begin
          if (d_exp_q.size() == 0) report_fail("grant_d", "no pending request");
          else cur = d_exp_q.pop_front();
          d_granted = 1;
        end else begin
          if (i_exp_q.size() == 0) report_fail("grant_i", "no pending request");
          else cur = i_exp_q.pop_front();
          i_granted = 1;
        end
      end else begin
        e_bv = 0;
      end
      check("handshake{bus_valid,instr_ready,mem_ready}",
            {bus_valid, instr_ready, mem_ready}, {e_bv, e_ir, e_mr});
      if (e_bv) check("bus_fields", {bus_instr, bus_addr, bus_wdata, bus_wstrb}, cur);
      if (comp) begin
        if (rd_q.size() == 0) report_fail("rdata_expect", "no rdata queued");
        else if (cur_d) m_mr = rd_q.pop_front();
        else m_ir = rd_q.pop_front();
      end
      check("rdata{instr,mem}", {instr_rdata, mem_rdata}, {m_ir, m_mr});
      if (instr_ready) begin n_ipulse++; grant_log.push_back(0); end
      if (mem_ready)   begin n_mpulse++; grant_log.push_back(1); end
      p_bv  = e_bv;
      p_rsp = e_ir || e_mr;
    end
  end

  task automatic wait_idle(input int bound);
    int t;
    bit idle;
    t = 0;
    idle = 0;
    while (!idle && t < bound) begin
      @(posedge clk);
      #3;
      t++;
      idle = (i_req_q.size() == 0) && (d_req_q.size() == 0) && !i_busy && !d_busy &&
             !bus_valid && !instr_ready && !mem_ready;
    end
    if (!idle) report_fail("idle_timeout", "arbiter still busy");
    @(posedge clk);
    #3;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=simulation not finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, bi, bd;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;

    // first conflicts after reset alternate starting with instruction
    fix_wait = 0;
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      i_req_q.push_back(mk_i(32'h1000 + 32'(16 * k)));
      d_req_q.push_back(mk_d(1'b0, 32'h2000 + 32'(16 * k), $urandom, 4'(k + 1)));
    end
    wait_idle(200);
    check("fair_count", 128'(grant_log.size()), 128'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check($sformatf("fair_order_%0d", k), 128'(grant_log[k]), 128'(k % 2));

    // single fetch
    grant_log.delete();
    rd_fix_q.push_back(32'h0000_0013);
    i_req_q.push_back(mk_i(32'h0000_0100));
    wait_idle(100);
    check("fetch_pulses", 128'(grant_log.size()), 128'd1);
    check("fetch_rdata", 128'(instr_rdata), 128'h13);

    // store held across 5 wait states; core changes its fields after grant
    grant_log.delete();
    fix_wait = 5;
    bd = n_mpulse;
    d_req_q.push_back(mk_d(1'b0, 32'h2000, 32'hDEAD_BEEF, 4'hF));
    wait_idle(100);
    check("store_mem_pulses", 128'(n_mpulse - bd), 128'd1);
    check("store_log", 128'(grant_log.size()), 128'd1);

    // bus_ready held high with no requests
    fix_wait = 0;
    stray_mode = 2;
    grant_log.delete();
    repeat (20) @(posedge clk);
    #3;
    check("stray_pulses", 128'(grant_log.size()), 128'd0);
    check("stray_bus_valid", 128'(bus_valid), 128'd0);
    stray_mode = 0;

    // reset while a data request waits on the bus
    fix_wait = 100;
    d_req_q.push_back(mk_d(1'b0, 32'h0000_5000, 32'h1234_5678, 4'h3));
    t = 0;
    while (!bus_valid && t < 50) begin
      @(posedge clk);
      #3;
      t++;
    end
    if (!bus_valid) report_fail("abort_grant", "bus_valid never rose");
    repeat (2) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("abort_async_bus_valid", 128'(bus_valid), 128'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    fix_wait = 0;
    bi = n_ipulse;
    bd = n_mpulse;
    i_req_q.push_back(mk_i(32'h0000_0400));
    wait_idle(100);
    check("abort_no_mem_ready", 128'(n_mpulse - bd), 128'd0);
    check("abort_instr_served", 128'(n_ipulse - bi), 128'd1);

    // randomized traffic with random wait states and stray bus_ready
    fix_wait = -1;
    stray_mode = 1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #3;
      if ($urandom_range(0, 2) == 0 && i_req_q.size() < 2)
        i_req_q.push_back(mk_i($urandom & 32'hFFFF_FFFC));
      if ($urandom_range(0, 2) == 0 && d_req_q.size() < 2)
        d_req_q.push_back(mk_d(1'($urandom), $urandom, $urandom, 4'($urandom)));
    end
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imt_mem_arbiter.md
IMT_MEM_ARBITER -- requirements
Module: imt_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: ADDR_RESET_PRIO, default 0, meaning the port favoured by the first simultaneous conflict after reset (0 = instruction, 1 = data).
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the input instr_valid, 1 bit: core instruction-fetch request.
REQ-005 The block SHALL have the input instr_addr, 32 bits: fetch address.
REQ-006 The block SHALL have the output instr_ready, 1 bit: fetch complete; one-cycle pulse.
REQ-007 The block SHALL have the output instr_rdata, 32 bits: fetched word; valid while instr_ready=1.
REQ-008 The block SHALL have the inputs mem_valid (1 bit), mem_instr (1 bit), mem_addr (32 bits), mem_wdata (32 bits) and mem_wstrb (4 bits): core data-port request.
REQ-009 The block SHALL have the outputs mem_ready (1 bit, one-cycle pulse) and mem_rdata (32 bits, valid while mem_ready=1).
REQ-010 The block SHALL have the outputs bus_valid (1 bit), bus_instr (1 bit), bus_addr (32 bits), bus_wdata (32 bits) and bus_wstrb (4 bits): merged downstream request.
REQ-011 The block SHALL have the inputs bus_ready (1 bit) and bus_rdata (32 bits): downstream completion and read data.

Function
REQ-012 The FSM SHALL have the states IDLE, BUS_I, BUS_D and RESP; all outputs SHALL be registered.
REQ-013 IDLE, exactly one valid: go to BUS_I (instr) or BUS_D (mem), latch that port's request fields into bus_*, and set bus_valid=1 on the same edge.
REQ-014 IDLE, both valid: grant the port opposite to last_grant, then update last_grant to the granted port.
REQ-015 last_grant SHALL reset to the complement of ADDR_RESET_PRIO, so that the first conflict grants ADDR_RESET_PRIO.
REQ-016 A BUS_I grant SHALL drive bus_instr=1, bus_wstrb=0 and bus_wdata=0 (the instruction port is read-only).
REQ-017 A BUS_D grant SHALL drive bus_instr=mem_instr and pass mem_wdata and mem_wstrb through unchanged.
REQ-018 In BUS_I and BUS_D, bus_valid and all latched bus_* fields SHALL stay stable until bus_ready=1 is sampled; core-side changes after the grant SHALL be ignored.
REQ-019 On the bus_ready edge in BUS_x: bus_valid<=0; the granted port's ready<=1 and its rdata<=bus_rdata; go to RESP.
REQ-020 RESP SHALL last exactly one cycle, with the ready pulse high; the next state is IDLE, and all readies <=0.
REQ-021 The other port's rdata SHALL hold its previous value; instr_ready and mem_ready SHALL never be high in the same cycle.
REQ-022 Latency: a request to an idle arbiter with zero-wait bus_ready SHALL complete with ready 3 cycles after valid is first sampled (grant, bus_ready, RESP).
REQ-023 A request arriving in BUS_x or RESP SHALL wait, with no effect on the current transaction, and be considered in the next IDLE.
REQ-024 bus_ready sampled while in IDLE or RESP SHALL be ignored.
REQ-025 Throughput: one transaction per 3 cycles minimum; there is no request queuing beyond the core's held valid.

Reset
REQ-026 While resetn=0 the block SHALL be in state IDLE, with bus_valid=0, bus_instr=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, instr_ready=0, mem_ready=0, instr_rdata=0, mem_rdata=0, and last_grant per REQ-015.
REQ-027 Reset asserted in mid-transaction SHALL abandon the transaction immediately; no ready pulse SHALL be issued for it after release.
REQ-028 After resetn rises, the first arbitration SHALL occur on the first clk edge with a valid request.

Verification
REQ-029 Single fetch: instr_valid=1, instr_addr=0x0000_0100, bus_ready returned 1 cycle after bus_valid with bus_rdata=0x0000_0013 -> bus_instr=1, bus_wstrb=0, then instr_ready pulse of 1 cycle with instr_rdata=0x0000_0013; mem_ready stays 0.
REQ-030 Store: mem_valid=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF, mem_wstrb=0xF -> bus fields match exactly and are held across 5 bus wait cycles; a single mem_ready pulse follows bus_ready.
REQ-031 Conflict fairness: both ports request continuously for 6 transactions from reset with ADDR_RESET_PRIO=0 -> grant order I, D, I, D, I, D.
REQ-032 Field stability: change mem_addr from 0x2000 to 0x3000 one cycle after the grant -> bus_addr remains 0x2000 until bus_ready.
REQ-033 Reset mid-operation: resetn=0 while in BUS_D with bus_ready not yet asserted -> bus_valid=0 asynchronously; after release there is no mem_ready pulse and a new instr request is served normally.
REQ-034 Stray bus_ready: bus_ready=1 held high while in IDLE with no requests -> no ready pulses and bus_valid remains 0.
